reload_down_counter: RTL and testbench

- Loadable down-counter. It decrements from all-ones to zero. At terminal count it reloads a queued value, or wraps to all-ones if no value is queued.
- Reload values enter through a valid/ready handshake into a one-entry holding register. This lets a producer queue the next period without stalling.
- Serves as the down-counting counterpart of the team's up-counting load-value counter, for reload timers and period generators.

---
 rtl/reload_down_counter.sv | 44 ++++
 tb/tb_reload_down_counter.sv | 76 +++++++
 2 files changed

// File: rtl/reload_down_counter.sv
// reload_down_counter: down-counter with a one-entry valid/ready reload queue (Clk, Rst, Enable, Load_Valid/Load_Value/Load_Ready in; Count, Reload_Pending, Terminal_Count out)
module reload_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic             Load_Valid,
  input  logic [WIDTH-1:0] Load_Value,
  output logic             Load_Ready,
  output logic [WIDTH-1:0] Count,
  output logic             Reload_Pending,
  output logic             Terminal_Count
);
  typedef enum logic {EMPTY, ARMED} state_t;
  state_t state;
  logic [WIDTH-1:0] hold;
  assign Load_Ready = state == EMPTY;
  assign Reload_Pending = state == ARMED;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Count <= '1;
      hold <= '0;
      state <= EMPTY;
      Terminal_Count <= 1'b0;
    end else begin
      Terminal_Count <= 1'b0;
      if (state == EMPTY && Load_Valid) begin
        state <= ARMED;
        hold <= Load_Value;
      end
      if (Enable) begin
        if (Count != '0) Count <= Count - 1'b1;
        else begin
          Terminal_Count <= 1'b1;
          if (state == ARMED) begin
            Count <= hold;
            state <= EMPTY;
          end else Count <= '1;
        end
      end
    end
  end
endmodule

// File: tb/tb_reload_down_counter.sv
// tb_reload_down_counter: directed scoreboard bench for reload_down_counter
module tb_reload_down_counter;
  logic clk = 1'b0;
  logic rst, en, lv;
  logic [3:0] lval;
  logic ready, pend, tc;
  logic [3:0] cnt;
  typedef struct packed {logic [3:0] c; logic r; logic p; logic t;} exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int idx = 0;
  always #5 clk = ~clk;
  reload_down_counter #(.WIDTH(4)) dut (
    .Clk(clk), .Rst(rst), .Enable(en), .Load_Valid(lv), .Load_Value(lval),
    .Load_Ready(ready), .Count(cnt), .Reload_Pending(pend), .Terminal_Count(tc)
  );
  task automatic step(input logic r, input logic e, input logic v, input logic [3:0] val,
                      input logic [3:0] ec, input logic er, input logic ep, input logic et);
    @(negedge clk);
    rst = r; en = e; lv = v; lval = val;
    q.push_back('{c: ec, r: er, p: ep, t: et});
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        idx++;
        tests += 4;
        if (cnt !== x.c) begin fails++; $display("FAIL count step %0d: got %0d expected %0d", idx, cnt, x.c); end
        if (ready !== x.r) begin fails++; $display("FAIL load_ready step %0d: got %b expected %b", idx, ready, x.r); end
        if (pend !== x.p) begin fails++; $display("FAIL reload_pending step %0d: got %b expected %b", idx, pend, x.p); end
        if (tc !== x.t) begin fails++; $display("FAIL terminal_count step %0d: got %b expected %b", idx, tc, x.t); end
      end
    end
  end
  initial begin
    rst = 1'b1; en = 1'b0; lv = 1'b0; lval = 4'd0;
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 15, 1, 0, 0);
    for (int i = 14; i >= 0; i--) step(0, 1, 0, 0, 4'(i), 1, 0, 0);
    step(0, 1, 0, 0, 15, 1, 0, 1);
    step(0, 1, 0, 0, 14, 1, 0, 0);
    for (int i = 13; i >= 10; i--) step(0, 1, 0, 0, 4'(i), 1, 0, 0);
    step(0, 1, 1, 5, 9, 0, 1, 0);
    for (int i = 8; i >= 0; i--) step(0, 1, 1, 3, 4'(i), 0, 1, 0);
    step(0, 1, 1, 3, 5, 1, 0, 1);
    step(0, 1, 1, 3, 4, 0, 1, 0);
    for (int i = 3; i >= 0; i--) step(0, 1, 0, 0, 4'(i), 0, 1, 0);
    step(0, 1, 0, 0, 3, 1, 0, 1);
    step(0, 1, 1, 0, 2, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 15, 1, 0, 1);
    step(0, 1, 1, 7, 14, 0, 1, 0);
    for (int i = 13; i >= 4; i--) step(0, 1, 0, 0, 4'(i), 0, 1, 0);
    step(1, 1, 1, 9, 15, 1, 0, 0);
    for (int i = 14; i >= 0; i--) step(0, 1, 0, 0, 4'(i), 1, 0, 0);
    step(0, 1, 0, 0, 15, 1, 0, 1);
    step(0, 1, 0, 0, 14, 1, 0, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
